// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - byte output handshake and status pulses of the UART receiver
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_BITS-1:0] m_data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;

    modport master (
        output m_valid,
        output m_data,
        output parity_err,
        output frame_err,
        output break_det,
        output overrun,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  parity_err,
        input  frame_err,
        input  break_det,
        input  overrun,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with three-sample majority vote
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 100,
    parameter int BIT_RATE  = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          uart_i,
    uart_rx_cfg_if.master m
);
    localparam int CYCLE = int'((64'(CLK_FREQ) * 64'd1_000_000) / 64'(BIT_RATE));
    localparam int CW    = $clog2(CYCLE);
    localparam int BW    = $clog2(DATA_BITS);

    localparam logic [CW-1:0] C_LAST = CW'(CYCLE - 1);
    localparam logic [CW-1:0] C_HM1  = CW'(CYCLE / 2 - 1);
    localparam logic [CW-1:0] C_H    = CW'(CYCLE / 2);
    localparam logic [CW-1:0] C_HP1  = CW'(CYCLE / 2 + 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           sync_q, sync_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 any_one_q, any_one_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 m_valid_q, m_valid_d;
    logic [DATA_BITS-1:0] m_data_q, m_data_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 brk_q, brk_d;
    logic                 ovr_q, ovr_d;

    // sync_q[1] is the synchronised line; sync_q[2] is its one-clock-old copy
    logic s_now;
    logic fall;
    logic at_hp1;
    logic at_last;
    logic bit_val;
    logic exp_par;
    logic last_stop;

    assign s_now     = sync_q[1];
    assign fall      = ~sync_q[1] & sync_q[2];
    assign at_hp1    = (cnt_q == C_HP1);
    assign at_last   = (cnt_q == C_LAST);
    assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & s_now) | (samp_q[1] & s_now);
    assign exp_par   = (PARITY == 1) ? ~(^shift_q) : (^shift_q);
    assign last_stop = (STOP_BITS == 1) || stop_idx_q;

    assign m.m_valid    = m_valid_q;
    assign m.m_data     = m_data_q;
    assign m.parity_err = pe_q;
    assign m.frame_err  = fe_q;
    assign m.break_det  = brk_q;
    assign m.overrun    = ovr_q;

    // Next-state logic: bit timing, sampling, frame assembly, evaluation and output handshake
    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[1:0], uart_i};
        cnt_d      = (state_q == IDLE || at_last) ? '0 : cnt_q + CW'(1);
        bit_d      = bit_q;
        stop_idx_d = stop_idx_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        any_one_d  = any_one_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        m_valid_d  = m_valid_q & ~m.m_ready;
        m_data_d   = m_data_q;
        pe_d       = 1'b0;
        fe_d       = 1'b0;
        brk_d      = 1'b0;
        ovr_d      = 1'b0;

        // First two votes are latched; the third is the live sample at H+1
        if (cnt_q == C_HM1) samp_d[0] = s_now;
        if (cnt_q == C_H)   samp_d[1] = s_now;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (at_hp1 && bit_val) begin
                    // Start bit did not hold low: treat as a glitch
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (at_last) begin
                    state_d    = DATA;
                    bit_d      = '0;
                    any_one_d  = 1'b0;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                end
            end
            DATA: begin
                if (at_hp1) begin
                    shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
                    any_one_d = any_one_q | bit_val;
                end
                if (at_last) begin
                    if (bit_q == B_LAST) begin
                        state_d    = (PARITY != 0) ? PAR : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PAR: begin
                if (at_hp1) begin
                    par_bad_d = (bit_val != exp_par);
                    any_one_d = any_one_q | bit_val;
                end
                if (at_last) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_hp1) begin
                    if (last_stop) begin
                        // Leave at mid stop bit so the next start edge is never missed
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (!(any_one_q | bit_val)) begin
                            brk_d = 1'b1;
                        end else if (stop_bad_q | ~bit_val) begin
                            fe_d = 1'b1;
                        end else if (par_bad_q) begin
                            pe_d = 1'b1;
                        end else if (m_valid_q & ~m.m_ready) begin
                            ovr_d = 1'b1;
                        end else begin
                            m_valid_d = 1'b1;
                            m_data_d  = shift_q;
                        end
                    end else begin
                        stop_bad_d = stop_bad_q | ~bit_val;
                        any_one_d  = any_one_q | bit_val;
                    end
                end else if (at_last) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Line synchroniser, reset to the idle-high level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Receiver state, frame accumulators, output byte and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_idx_q <= 1'b0;
            samp_q     <= '0;
            shift_q    <= '0;
            any_one_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop_idx_q <= stop_idx_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            any_one_q  <= any_one_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
        end
    end
endmodule
